// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Entry bundle pushed from pc/cache toward decode.
package fetch_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        comp;
    } fetch_entry_t;

    localparam logic [63:0] PC_STEP_FULL = 64'd4;
    localparam logic [63:0] PC_STEP_COMP = 64'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO buffering fetched entries toward decode.
// Pointers carry a wrap bit to tell full from empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    fetch_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ONE;
            if (pop)
                rd_ptr <= rd_ptr + ONE;
        end
    end

    // Storage write; cleared on reset so outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC generator and fetch buffer between instcache and decode.
// Redirects replace pc and flush buffered entries.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_1000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] pc,
    input  logic        inst_valid,
    input  logic        inst_comp,
    input  logic [31:0] inst,
    input  logic        request,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_comp
);

    fetch_entry_t din;
    fetch_entry_t dout;
    logic         empty;
    logic         full;
    logic         pop;
    logic         accept;
    logic [63:0]  step;
    logic         unused;

    assign unused = ^{request, redirect_pc[0]};

    assign pop    = out_valid & out_ready;
    assign accept = inst_valid & ~redirect_valid
                  & (~full | pop);
    assign step   = inst_comp ? PC_STEP_COMP
                              : PC_STEP_FULL;

    assign din.pc   = pc;
    assign din.inst = inst_comp ? {16'h0, inst[15:0]}
                                : inst;
    assign din.comp = inst_comp;

    assign out_valid = ~empty;
    assign out_pc    = dout.pc;
    assign out_inst  = dout.inst;
    assign out_comp  = dout.comp;

    // Fetch address: redirect first, then sequential advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (redirect_valid)
            pc <= {redirect_pc[63:1], 1'b0};
        else if (accept)
            pc <= pc + step;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (accept),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// Each scenario task checks its own expectations inline.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc;
    logic        inst_valid;
    logic        inst_comp;
    logic [31:0] inst;
    logic        request;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_comp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .inst_valid     (inst_valid),
        .inst_comp      (inst_comp),
        .inst           (inst),
        .request        (request),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_comp       (out_comp)
    );

    function automatic logic [31:0] full_word(input logic [63:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    function automatic logic [31:0] comp_word(input logic [63:0] a);
        return {16'hbeef, a[11:0], 4'h1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        inst_valid     = 1'b0;
        inst_comp      = 1'b0;
        inst           = '0;
        request        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [63:0] exp_pc;
        do_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if (pc !== 64'h1000) begin
            bad++;
            $display("FAIL reset_pc got=%h want=%h", pc, 64'h1000);
        end
        total++;
        if (out_valid !== 1'b0 || out_pc !== 64'h0
            || out_inst !== 32'h0 || out_comp !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got v=%b pc=%h i=%h c=%b want 0",
                     out_valid, out_pc, out_inst, out_comp);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 64'h1000 + 64'(4 * i);
            inst_valid = 1'b1;
            inst_comp  = 1'b0;
            inst       = full_word(exp_pc);
            total++;
            if (pc !== exp_pc) begin
                bad++;
                $display("FAIL stream_pc%0d got=%h want=%h", i, pc, exp_pc);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc
                || out_inst !== full_word(exp_pc)) begin
                bad++;
                $display("FAIL stream_out%0d got v=%b pc=%h i=%h want pc=%h i=%h",
                         i, out_valid, out_pc, out_inst, exp_pc, full_word(exp_pc));
            end
        end
        inst_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_mixed();
        logic        cs [4];
        logic [63:0] ps [4];
        logic [31:0] w;
        cs[0] = 1'b1; cs[1] = 1'b0; cs[2] = 1'b1; cs[3] = 1'b0;
        ps[0] = 64'h1000; ps[1] = 64'h1002;
        ps[2] = 64'h1006; ps[3] = 64'h1008;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_valid = 1'b1;
            inst_comp  = cs[i];
            inst       = cs[i] ? comp_word(ps[i]) : full_word(ps[i]);
            total++;
            if (pc !== ps[i]) begin
                bad++;
                $display("FAIL mixed_pc%0d got=%h want=%h", i, pc, ps[i]);
            end
            w = cs[i] ? {16'h0, comp_word(ps[i]) & 32'hffff}
                      : full_word(ps[i]);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_pc !== ps[i]
                || out_inst !== w || out_comp !== cs[i]) begin
                bad++;
                $display("FAIL mixed_out%0d got pc=%h i=%h c=%b want pc=%h i=%h c=%b",
                         i, out_pc, out_inst, out_comp, ps[i], w, cs[i]);
            end
        end
        inst_valid = 1'b0;
        inst_comp  = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [63:0] ps [3];
        ps[0] = 64'h1000; ps[1] = 64'h1004; ps[2] = 64'h1008;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_valid = 1'b1;
            inst_comp  = 1'b0;
            inst       = full_word(pc);
            tick();
        end
        total++;
        if (pc !== 64'h1008) begin
            bad++;
            $display("FAIL bp_pc_hold got=%h want=%h", pc, 64'h1008);
        end
        total++;
        if (out_valid !== 1'b1 || out_pc !== 64'h1000) begin
            bad++;
            $display("FAIL bp_head got v=%b pc=%h want v=1 pc=%h",
                     out_valid, out_pc, 64'h1000);
        end
        out_ready = 1'b1;
        inst_valid = 1'b1;
        inst = full_word(64'h1008);
        tick();
        total++;
        if (pc !== 64'h100c || out_pc !== ps[1] || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_pushpop got pc=%h head=%h want pc=%h head=%h",
                     pc, out_pc, 64'h100c, ps[1]);
        end
        inst_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_pc !== ps[2]
            || out_inst !== full_word(ps[2])) begin
            bad++;
            $display("FAIL bp_third got v=%b pc=%h i=%h want pc=%h i=%h",
                     out_valid, out_pc, out_inst, ps[2], full_word(ps[2]));
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty got=%b want=0", out_valid);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inst_valid = 1'b1;
            inst_comp  = 1'b0;
            inst       = full_word(pc);
            tick();
        end
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2003;
        inst           = full_word(64'h1008);
        tick();
        total++;
        if (out_valid !== 1'b0 || pc !== 64'h2002) begin
            bad++;
            $display("FAIL redir_flush got v=%b pc=%h want v=0 pc=%h",
                     out_valid, pc, 64'h2002);
        end
        redirect_valid = 1'b0;
        inst = full_word(64'h2002);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 64'h2002
            || out_inst !== full_word(64'h2002)) begin
            bad++;
            $display("FAIL redir_next got v=%b pc=%h i=%h want pc=%h i=%h",
                     out_valid, out_pc, out_inst, 64'h2002, full_word(64'h2002));
        end
        inst_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hffff_ffff_ffff_fffe;
        tick();
        redirect_valid = 1'b0;
        inst_valid     = 1'b1;
        inst_comp      = 1'b0;
        inst           = 32'h0000_0013;
        tick();
        inst_valid = 1'b0;
        total++;
        if (pc !== 64'h2) begin
            bad++;
            $display("FAIL wrap_pc got=%h want=%h", pc, 64'h2);
        end
        total++;
        if (out_valid !== 1'b1 || out_pc !== 64'hffff_ffff_ffff_fffe) begin
            bad++;
            $display("FAIL wrap_out got v=%b pc=%h want pc=%h",
                     out_valid, out_pc, 64'hffff_ffff_ffff_fffe);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inst_valid = 1'b1;
            inst_comp  = 1'b0;
            inst       = full_word(pc);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || pc !== 64'h1000 || out_pc !== 64'h0) begin
            bad++;
            $display("FAIL async_rst got v=%b pc=%h head=%h want v=0 pc=%h head=0",
                     out_valid, pc, out_pc, 64'h1000);
        end
        inst_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
